// File: rtl/dport_responder_pkg.sv
// Shared constants, FSM encodings and the latched request record for the
// data-port responder and its performance-counter bank.
package dport_responder_pkg;

  localparam logic [15:0] DPORT_MMIO_BASE = 16'hFFF6;
  localparam int          DPORT_NUM_CTRS  = 5;
  localparam int          DPORT_CTR_WIDTH = 16;

  localparam int CTR_IHIT    = 0;
  localparam int CTR_IMISS   = 1;
  localparam int CTR_DHIT    = 2;
  localparam int CTR_DMISS   = 3;
  localparam int CTR_MISPRED = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MMIO = 2'd1;
  localparam logic [1:0] ST_PMEM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } req_t;

endpackage

// File: rtl/dport_responder_if.sv
// Request/acknowledge bus between the MEM-stage controller (master) and the
// data-port responder (slave).
interface dport_responder_if;
  logic        req_rw;
  logic        wr_en;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_byte_en;
  logic        rw_resp;
  logic [15:0] resp_rdata;

  modport master (
    output req_rw, wr_en, req_addr, req_wdata, req_byte_en,
    input  rw_resp, resp_rdata
  );

  modport slave (
    input  req_rw, wr_en, req_addr, req_wdata, req_byte_en,
    output rw_resp, resp_rdata
  );
endinterface

// File: rtl/dport_responder_perf_ctr_bank.sv
// Bank of saturating event counters with a single clear port and a read mux;
// a clear on a counter takes priority over its same-cycle increment.
module perf_ctr_bank #(
  parameter int NUM_CTRS  = 5,
  parameter int CTR_WIDTH = 16,
  parameter int IDXW      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CTRS-1:0]  inc_i,
  input  logic                 clr_en_i,
  input  logic [IDXW-1:0]      clr_sel_i,
  input  logic [IDXW-1:0]      rd_sel_i,
  output logic [CTR_WIDTH-1:0] rd_data_o
);

  logic [CTR_WIDTH-1:0] ctr_q [NUM_CTRS];

  function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CTRS; k++) begin
      if (rst) begin
        ctr_q[k] <= '0;
      end else if (clr_en_i && (clr_sel_i == IDXW'(k))) begin
        ctr_q[k] <= '0;
      end else if (inc_i[k]) begin
        ctr_q[k] <= sat_inc(ctr_q[k]);
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_CTRS; k++) begin
      if (rd_sel_i == IDXW'(k)) rd_data_o = ctr_q[k];
    end
  end

endmodule

// File: rtl/dport_responder.sv
// Data-port responder: serves MMIO counter accesses locally and forwards all
// other requests to physical memory, returning a one-cycle rw_resp pulse.
module dport_responder import dport_responder_pkg::*; #(
  parameter logic [15:0] MMIO_BASE = DPORT_MMIO_BASE,
  parameter int          NUM_CTRS  = DPORT_NUM_CTRS,
  parameter int          CTR_WIDTH = DPORT_CTR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  dport_responder_if.slave    bus,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [15:0]         pmem_address,
  output logic [15:0]         pmem_wdata,
  output logic [1:0]          pmem_byte_enable,
  input  logic                pmem_resp,
  input  logic [15:0]         pmem_rdata,
  input  logic [NUM_CTRS-1:0] ctr_event
);

  localparam int IDXW = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        resp_q, resp_d;
  logic [15:0] rdata_q, rdata_d;

  logic [IDXW-1:0]      ctr_sel;
  logic                 ctr_clr;
  logic [CTR_WIDTH-1:0] ctr_rdata;

  // Counters sit on even word addresses; matching on addr[15:1] drops addr[0].
  always_comb begin
    ctr_sel = '0;
    for (int k = 0; k < NUM_CTRS; k++) begin
      if (req_q.addr[15:1] == 15'((MMIO_BASE >> 1) + k)) ctr_sel = IDXW'(k);
    end
  end

  assign ctr_clr = (state_q == ST_MMIO) && req_q.we;

  perf_ctr_bank #(
    .NUM_CTRS  (NUM_CTRS),
    .CTR_WIDTH (CTR_WIDTH),
    .IDXW      (IDXW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (ctr_event),
    .clr_en_i  (ctr_clr),
    .clr_sel_i (ctr_sel),
    .rd_sel_i  (ctr_sel),
    .rd_data_o (ctr_rdata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_rw) begin
          req_d = '{we: bus.wr_en, addr: bus.req_addr,
                    wdata: bus.req_wdata, be: bus.req_byte_en};
          if (bus.req_addr >= MMIO_BASE) begin
            state_d = ST_MMIO;
          end else begin
            state_d = ST_PMEM;
            rd_d    = !bus.wr_en;
            wr_d    = bus.wr_en;
          end
        end
      end
      ST_MMIO: begin
        resp_d  = 1'b1;
        if (!req_q.we) rdata_d = 16'(ctr_rdata);
        state_d = ST_DONE;
      end
      ST_PMEM: begin
        if (pmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          resp_d  = 1'b1;
          if (!req_q.we) rdata_d = pmem_rdata;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign pmem_read        = rd_q;
  assign pmem_write       = wr_q;
  assign pmem_address     = req_q.addr;
  assign pmem_wdata       = req_q.wdata;
  assign pmem_byte_enable = req_q.be;
  assign bus.rw_resp      = resp_q;
  assign bus.resp_rdata   = rdata_q;

endmodule
